// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch stage and its instruction RAM.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int PC_W    = 6;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_ram.sv
// Single-port synchronous instruction RAM with a registered read port.
// Latency: write lands on the clock edge; read data is valid one edge after re.
// Backpressure: none; the caller never asserts we and re together.
//
// Ports:
//   clk   - clock, all state on rising edge
//   we    - write enable, writes wdata to mem[addr]
//   re    - read enable, captures mem[addr] into rdata
//   addr  - shared read/write address
//   wdata - write data
//   rdata - registered read data, held until the next read
module instr_ram #(
    parameter int W     = 16,
    parameter int AW    = 6,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] rdata_q;

    // Contents are deliberately not reset; the fetch stage masks stale words.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction memory + fetch stage: loads a program stream, then fetches RAM[pc] per PC strobe.
// Latency: pc_lat_clk at N -> instr_valid low at N+1, new instr valid at N+2 (1 instr / 2 cycles).
// Backpressure: none; loads accepted every cycle, writes beyond DEPTH words are dropped.
//
// Ports:
//   clka        - clock
//   reset_in    - asynchronous active-low reset
//   we_ins      - program-load write enable (also forces a reload from FETCH/EXEC)
//   load        - program word to store
//   pc          - current PC
//   pc_lat_clk  - one-cycle strobe, PC just updated
//   instr       - instruction for the decoder
//   instr_valid - instr corresponds to the current pc
//   load_count  - words loaded since the last load start (0..DEPTH)
//   mem_full    - load_count == DEPTH
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int INSTR_W = cpu_pkg::INSTR_W,
    parameter int PC_W    = cpu_pkg::PC_W,
    parameter int DEPTH   = 64
) (
    input  logic               clka,
    input  logic               reset_in,
    input  logic               we_ins,
    input  logic [INSTR_W-1:0] load,
    input  logic [PC_W-1:0]    pc,
    input  logic               pc_lat_clk,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W:0]      load_count,
    output logic               mem_full
);

    localparam logic [PC_W:0] FULL_CNT = (PC_W+1)'(DEPTH);
    localparam logic [PC_W:0] ONE_CNT  = (PC_W+1)'(1);

    fetch_state_t       state_q;
    logic [PC_W:0]      load_count_q;
    logic               instr_valid_q;
    logic               nop_q;

    logic               ram_we;
    logic               ram_re;
    logic [PC_W-1:0]    ram_addr;
    logic [INSTR_W-1:0] ram_rdata;

    assign mem_full = (load_count_q == FULL_CNT);

    // RAM port steering. A reload from FETCH/EXEC writes address 0 and
    // suppresses the read, so the port is never used for both at once.
    always_comb begin
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = pc;
        case (state_q)
            LOAD: begin
                if (we_ins && !mem_full) begin
                    ram_we   = 1'b1;
                    ram_addr = load_count_q[PC_W-1:0];
                end
            end
            FETCH, EXEC: begin
                if (we_ins) begin
                    ram_we   = 1'b1;
                    ram_addr = '0;
                end else if (state_q == FETCH) begin
                    ram_re = 1'b1;
                end
            end
            default: ;
        endcase
    end

    instr_ram #(
        .W     (INSTR_W),
        .AW    (PC_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clka),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (load),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clka or negedge reset_in) begin
        if (!reset_in) begin
            state_q       <= LOAD;
            load_count_q  <= '0;
            instr_valid_q <= 1'b0;
            nop_q         <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (we_ins) begin
                        if (!mem_full) begin
                            load_count_q <= load_count_q + ONE_CNT;
                        end
                    end else if (load_count_q != '0) begin
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (we_ins) begin
                        state_q       <= LOAD;
                        instr_valid_q <= 1'b0;
                        load_count_q  <= ONE_CNT;
                    end else begin
                        // Addresses not written by the current load read as NOP.
                        nop_q         <= ({1'b0, pc} >= load_count_q);
                        instr_valid_q <= 1'b1;
                        state_q       <= EXEC;
                    end
                end
                EXEC: begin
                    if (we_ins) begin
                        state_q       <= LOAD;
                        instr_valid_q <= 1'b0;
                        load_count_q  <= ONE_CNT;
                    end else if (pc_lat_clk) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= FETCH;
                    end
                end
                default: begin
                    state_q       <= LOAD;
                    instr_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Both mux inputs are registers; RAM data only changes on a fetch,
    // so instr holds its last value until the next FETCH completes.
    assign instr       = nop_q ? NOP_INSTR : ram_rdata;
    assign instr_valid = instr_valid_q;
    assign load_count  = load_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch.
// Latency: inputs driven 1ns after a rising edge, outputs sampled there too.
// Backpressure: n/a.
module tb_instr_fetch;

    logic        clka;
    logic        reset_in;
    logic        we_ins;
    logic [15:0] load;
    logic [5:0]  pc;
    logic        pc_lat_clk;
    logic [15:0] instr;
    logic        instr_valid;
    logic [6:0]  load_count;
    logic        mem_full;

    int checks;
    int errors;

    instr_fetch dut (
        .clka        (clka),
        .reset_in    (reset_in),
        .we_ins      (we_ins),
        .load        (load),
        .pc          (pc),
        .pc_lat_clk  (pc_lat_clk),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_count  (load_count),
        .mem_full    (mem_full)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic test_reset();
        reset_in   = 1'b0;
        we_ins     = 1'b0;
        load       = 16'h0;
        pc         = 6'd0;
        pc_lat_clk = 1'b0;
        tick();
        tick();
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || load_count !== 7'd0 || mem_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: instr=%h valid=%b count=%0d full=%b, want 0000/0/0/0",
                     instr, instr_valid, load_count, mem_full);
        end
        @(negedge clka);
        reset_in = 1'b1;
        #6;
    endtask

    task automatic test_load_and_first_fetch();
        logic [15:0] words [3];
        words[0] = 16'h1111;
        words[1] = 16'h2222;
        words[2] = 16'h3333;
        for (int i = 0; i < 3; i++) begin
            we_ins = 1'b1;
            load   = words[i];
            tick();
        end
        we_ins = 1'b0;
        pc     = 6'd1;
        checks++;
        if (load_count !== 7'd3) begin
            errors++;
            $display("FAIL load_count_3: got %0d want 3", load_count);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_fetch_invalid: valid=%b want 0", instr_valid);
        end
        tick();
        checks++;
        if (instr !== 16'h2222 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_instr: instr=%h valid=%b want 2222/1", instr, instr_valid);
        end
    endtask

    task automatic test_pc_strobe();
        pc         = 6'd2;
        pc_lat_clk = 1'b1;
        tick();
        pc_lat_clk = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || instr !== 16'h2222) begin
            errors++;
            $display("FAIL strobe_fetch_cycle: instr=%h valid=%b want 2222/0", instr, instr_valid);
        end
        tick();
        checks++;
        if (instr !== 16'h3333 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL strobe_pc2: instr=%h valid=%b want 3333/1", instr, instr_valid);
        end
    endtask

    task automatic test_nop_beyond_count();
        pc         = 6'd5;
        pc_lat_clk = 1'b1;
        tick();
        pc_lat_clk = 1'b0;
        tick();
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL nop_pc5: instr=%h valid=%b want 0000/1", instr, instr_valid);
        end
    endtask

    task automatic test_full_load();
        // Starts in EXEC: first write is a reload at address 0.
        for (int i = 0; i < 70; i++) begin
            we_ins = 1'b1;
            load   = 16'(i);
            tick();
            if (i == 62) begin
                checks++;
                if (mem_full !== 1'b0 || load_count !== 7'd63) begin
                    errors++;
                    $display("FAIL before_full: count=%0d full=%b want 63/0", load_count, mem_full);
                end
            end
            if (i == 63) begin
                checks++;
                if (mem_full !== 1'b1 || load_count !== 7'd64) begin
                    errors++;
                    $display("FAIL full_at_64: count=%0d full=%b want 64/1", load_count, mem_full);
                end
            end
        end
        checks++;
        if (mem_full !== 1'b1 || load_count !== 7'd64) begin
            errors++;
            $display("FAIL full_saturate: count=%0d full=%b want 64/1", load_count, mem_full);
        end
        we_ins = 1'b0;
        pc     = 6'd63;
        tick();
        tick();
        checks++;
        if (instr !== 16'h003F || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_pc63: instr=%h valid=%b want 003f/1", instr, instr_valid);
        end
        pc         = 6'd5;
        pc_lat_clk = 1'b1;
        tick();
        pc_lat_clk = 1'b0;
        tick();
        checks++;
        if (instr !== 16'h0005) begin
            errors++;
            $display("FAIL no_wrap_pc5: instr=%h want 0005", instr);
        end
    endtask

    task automatic test_long_strobe();
        pc         = 6'd10;
        pc_lat_clk = 1'b1;
        tick();
        tick();
        checks++;
        if (instr !== 16'h000A || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL long_strobe_fetch: instr=%h valid=%b want 000a/1", instr, instr_valid);
        end
        pc_lat_clk = 1'b0;
        tick();
        checks++;
        if (instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL long_strobe_hold: valid=%b want 1", instr_valid);
        end
    endtask

    task automatic test_reload_priority();
        we_ins     = 1'b1;
        load       = 16'hABCD;
        pc_lat_clk = 1'b1;
        tick();
        we_ins     = 1'b0;
        pc_lat_clk = 1'b0;
        pc         = 6'd1;
        checks++;
        if (instr_valid !== 1'b0 || load_count !== 7'd1 || mem_full !== 1'b0) begin
            errors++;
            $display("FAIL reload: valid=%b count=%0d full=%b want 0/1/0", instr_valid, load_count, mem_full);
        end
        tick();
        tick();
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL reload_pc1_nop: instr=%h valid=%b want 0000/1", instr, instr_valid);
        end
        pc         = 6'd0;
        pc_lat_clk = 1'b1;
        tick();
        pc_lat_clk = 1'b0;
        tick();
        checks++;
        if (instr !== 16'hABCD || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL reload_pc0: instr=%h valid=%b want abcd/1", instr, instr_valid);
        end
    endtask

    task automatic test_reset_mid_load();
        we_ins = 1'b1;
        load   = 16'h5555;
        tick();
        load   = 16'h6666;
        tick();
        #2;
        reset_in = 1'b0;
        #1;
        checks++;
        if (instr !== 16'h0000 || instr_valid !== 1'b0 || load_count !== 7'd0 || mem_full !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: instr=%h valid=%b count=%0d full=%b want 0000/0/0/0",
                     instr, instr_valid, load_count, mem_full);
        end
        we_ins = 1'b0;
        @(negedge clka);
        reset_in = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || load_count !== 7'd0) begin
            errors++;
            $display("FAIL stay_in_load: valid=%b count=%0d want 0/0", instr_valid, load_count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_and_first_fetch();
        test_pc_strobe();
        test_nop_beyond_count();
        test_full_load();
        test_long_strobe();
        test_reload_priority();
        test_reset_mid_load();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
